// File: rtl/lsu_pkg.sv
// Shared types and helpers for the RV32 load/store initiator: funct3 encoding,
// per-command bookkeeping, and the lane shuffling used on requests and responses.
package lsu_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'd0,
    F3_H  = 3'd1,
    F3_W  = 3'd2,
    F3_BU = 3'd4,
    F3_HU = 3'd5
  } funct3_e;

  typedef struct packed {
    logic       we;
    logic [2:0] funct3;
    logic [1:0] off;
    logic       err;
  } meta_t;

  // funct3[1:0] alone encodes the access size; bit 2 only selects zero-extension
  function automatic logic [3:0] mk_mask(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'd0:    mk_mask = 4'b0001 << off;
      2'd1:    mk_mask = 4'b0011 << off;
      default: mk_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [3:0][7:0] mk_wdata(input logic [2:0] f3, input logic [31:0] w);
    case (f3[1:0])
      2'd0:    mk_wdata = {4{w[7:0]}};
      2'd1:    mk_wdata = {2{w[15:0]}};
      default: mk_wdata = w;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'd1:    is_misaligned = off[0];
      2'd2:    is_misaligned = (off != 2'd0);
      default: is_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] extract_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [3:0][7:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[off];
    h = {d[off + 2'd1], d[off]};
    case (f3)
      F3_B:    extract_load = {{24{b[7]}}, b};
      F3_BU:   extract_load = {24'h0, b};
      F3_H:    extract_load = {{16{h[15]}}, h};
      F3_HU:   extract_load = {16'h0, h};
      default: extract_load = d;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with occupancy counter; full reflects entries held only,
// so a pop never frees a slot for a push in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rstf,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: zero-cycle request pass-through to the data RAM, with
// in-order responses rebuilt from a meta FIFO and a read-data FIFO.
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int DEPTH       = 8192,
  parameter int AW          = $clog2(DEPTH) + 2,
  parameter int OUTSTANDING = 2
) (
  input  logic                 clk,
  input  logic                 rstf,
  input  logic                 t_req_valid,
  output logic                 t_req_ready,
  input  logic                 t_req_we,
  input  logic [2:0]           t_req_funct3,
  input  logic [31:0]          t_req_addr,
  input  logic [31:0]          t_req_wdata,
  output logic                 i_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [31:0]          i_rsp_data,
  output logic                 i_rsp_err,
  output logic                 i_mem_valid,
  input  logic                 i_mem_ready,
  output logic                 i_mem_we,
  output logic [AW-1:0]        i_mem_addr,
  output logic [3:0][7:0]      i_mem_data,
  output logic [3:0]           i_mem_mask,
  input  logic                 t_mem_valid,
  output logic                 t_mem_ready,
  input  logic [3:0][7:0]      t_mem_data
);
  localparam int LW = $clog2(OUTSTANDING + 1);

  logic [1:0]      off;
  logic            illegal, err, acc;
  meta_t           meta_in, meta_head;
  logic            meta_full, meta_empty, meta_pop;
  logic [3:0][7:0] data_head;
  logic            data_empty, data_push, data_pop;
  logic            rsp_blank, rsp_fire;
  logic [LW-1:0]   lif_q, lif_d;
  logic            unused_data_full;
  logic            unused_addr_hi;

  assign off     = t_req_addr[1:0];
  assign illegal = (t_req_funct3 == 3'd3) || (t_req_funct3[2:1] == 2'b11);
  assign err     = illegal | is_misaligned(t_req_funct3, off);

  // error commands never reach the RAM but still take a response slot
  assign i_mem_valid = t_req_valid & ~meta_full & ~err;
  assign t_req_ready = ~meta_full & (err | i_mem_ready);
  assign acc         = t_req_valid & t_req_ready;
  assign i_mem_we    = t_req_we;
  assign i_mem_addr  = {t_req_addr[AW-1:2], 2'b00};
  assign i_mem_mask  = mk_mask(t_req_funct3, off);
  assign i_mem_data  = mk_wdata(t_req_funct3, t_req_wdata);
  assign t_mem_ready = 1'b1;
  assign unused_addr_hi = &{1'b0, t_req_addr[31:AW]};

  assign meta_in = '{we: t_req_we, funct3: t_req_funct3, off: off, err: err};

  sync_fifo #(.WIDTH($bits(meta_t)), .DEPTH(OUTSTANDING)) u_meta (
    .clk(clk), .rstf(rstf), .push(acc), .wdata(meta_in), .pop(meta_pop),
    .rdata(meta_head), .full(meta_full), .empty(meta_empty)
  );

  // read data with no load outstanding is left over from before a reset
  assign data_push = t_mem_valid & (lif_q != '0);

  always_comb begin
    lif_d = lif_q;
    if (acc & ~t_req_we & ~err) lif_d = lif_d + LW'(1);
    if (data_push)              lif_d = lif_d - LW'(1);
  end

  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) lif_q <= '0;
    else       lif_q <= lif_d;
  end

  sync_fifo #(.WIDTH(32), .DEPTH(OUTSTANDING)) u_data (
    .clk(clk), .rstf(rstf), .push(data_push), .wdata(t_mem_data), .pop(data_pop),
    .rdata(data_head), .full(unused_data_full), .empty(data_empty)
  );

  assign rsp_blank   = meta_head.we | meta_head.err;
  assign i_rsp_valid = ~meta_empty & (rsp_blank | ~data_empty);
  assign rsp_fire    = i_rsp_valid & i_rsp_ready;
  assign meta_pop    = rsp_fire;
  assign data_pop    = rsp_fire & ~rsp_blank;
  assign i_rsp_err   = ~meta_empty & meta_head.err;
  assign i_rsp_data  = (meta_empty | rsp_blank) ? 32'h0
                     : extract_load(meta_head.funct3, meta_head.off, data_head);

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Bench for lsu_mem_initiator: directed scenarios with a latency-1 RAM model and
// an in-order response scoreboard.
module tb_lsu_mem_initiator;
  localparam int AW = $clog2(8192) + 2;

  logic            clk = 1'b0;
  logic            rstf;
  logic            t_req_valid, t_req_ready, t_req_we;
  logic [2:0]      t_req_funct3;
  logic [31:0]     t_req_addr, t_req_wdata;
  logic            i_rsp_valid, i_rsp_ready, i_rsp_err;
  logic [31:0]     i_rsp_data;
  logic            i_mem_valid, i_mem_ready, i_mem_we;
  logic [AW-1:0]   i_mem_addr;
  logic [3:0][7:0] i_mem_data;
  logic [3:0]      i_mem_mask;
  logic            t_mem_valid = 1'b0;
  logic            t_mem_ready;
  logic [3:0][7:0] t_mem_data = '0;

  typedef struct { logic err; logic [31:0] data; } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  logic            mv_s, we_s;
  logic [3:0]      mask_s;
  logic [31:0]     mdata_s;
  logic [AW-1:0]   addr_s;

  always #5 clk = ~clk;

  lsu_mem_initiator dut (
    .clk(clk), .rstf(rstf),
    .t_req_valid(t_req_valid), .t_req_ready(t_req_ready), .t_req_we(t_req_we),
    .t_req_funct3(t_req_funct3), .t_req_addr(t_req_addr), .t_req_wdata(t_req_wdata),
    .i_rsp_valid(i_rsp_valid), .i_rsp_ready(i_rsp_ready), .i_rsp_data(i_rsp_data),
    .i_rsp_err(i_rsp_err),
    .i_mem_valid(i_mem_valid), .i_mem_ready(i_mem_ready), .i_mem_we(i_mem_we),
    .i_mem_addr(i_mem_addr), .i_mem_data(i_mem_data), .i_mem_mask(i_mem_mask),
    .t_mem_valid(t_mem_valid), .t_mem_ready(t_mem_ready), .t_mem_data(t_mem_data)
  );

  // RAM model: writes land at the request edge, reads return one cycle later
  logic [31:0] ram [0:255] = '{default: 32'h0};
  always @(posedge clk) begin
    t_mem_valid <= 1'b0;
    if (i_mem_valid && i_mem_ready) begin
      if (i_mem_we) begin
        for (int b = 0; b < 4; b++)
          if (i_mem_mask[b]) ram[i_mem_addr[9:2]][b*8 +: 8] <= i_mem_data[b];
      end else begin
        t_mem_valid <= 1'b1;
        t_mem_data  <= ram[i_mem_addr[9:2]];
      end
    end
  end

  // scoreboard: every response handshake pops the oldest expectation
  always @(negedge clk) begin
    #2;
    if (rstf && i_rsp_valid && i_rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rsp_unexpected: got data=%08h err=%0b, none expected", i_rsp_data, i_rsp_err);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (i_rsp_data !== e.data) begin
          errors++;
          $display("FAIL rsp_data: got %08h expected %08h", i_rsp_data, e.data);
        end
        checks++;
        if (i_rsp_err !== e.err) begin
          errors++;
          $display("FAIL rsp_err: got %0b expected %0b", i_rsp_err, e.err);
        end
      end
    end
  end

  // caller sits at a negedge with the request fields driven
  task automatic wait_accept(input logic e_err, input logic [31:0] e_data);
    bit done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (t_req_ready) begin
        mv_s = i_mem_valid; we_s = i_mem_we; mask_s = i_mem_mask;
        mdata_s = i_mem_data; addr_s = i_mem_addr;
        exp_q.push_back('{err: e_err, data: e_data});
        @(posedge clk);
        #1 t_req_valid = 1'b0;
        done = 1;
      end else begin
        @(negedge clk);
      end
    end
    checks++;
    if (!done) begin
      errors++;
      t_req_valid = 1'b0;
      $display("FAIL accept_timeout: t_req_ready stayed %0b, expected 1", t_req_ready);
    end
  endtask

  task automatic drive_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd);
    @(negedge clk);
    t_req_valid = 1'b1; t_req_we = we; t_req_funct3 = f3;
    t_req_addr = addr; t_req_wdata = wd;
  endtask

  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input logic e_err, input logic [31:0] e_data);
    drive_req(we, f3, addr, wd);
    wait_accept(e_err, e_data);
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rstf = 1'b0; t_req_valid = 1'b0; t_req_we = 1'b0; t_req_funct3 = 3'd0;
    t_req_addr = '0; t_req_wdata = '0; i_rsp_ready = 1'b1; i_mem_ready = 1'b1;
    #12;
    checks++;
    if (i_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %0b expected 0", i_rsp_valid); end
    checks++;
    if (i_mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid: got %0b expected 0", i_mem_valid); end
    checks++;
    if (t_mem_ready !== 1'b1) begin errors++; $display("FAIL reset_mem_ready: got %0b expected 1", t_mem_ready); end
    checks++;
    if (t_req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %0b expected 1", t_req_ready); end
    rstf = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_sw_lw();
    bit seen = 0;
    send(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
    checks++;
    if (mask_s !== 4'hF || mdata_s !== 32'hDEADBEEF || we_s !== 1'b1 || mv_s !== 1'b1) begin
      errors++;
      $display("FAIL sw_req: got mask=%h data=%08h we=%0b mv=%0b expected F DEADBEEF 1 1", mask_s, mdata_s, we_s, mv_s);
    end
    checks++;
    if (addr_s !== AW'(32'h10)) begin errors++; $display("FAIL sw_addr: got %h expected 10", addr_s); end
    send(1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
    checks++;
    if (mask_s !== 4'hF || we_s !== 1'b0 || mv_s !== 1'b1) begin
      errors++;
      $display("FAIL lw_req: got mask=%h we=%0b mv=%0b expected F 0 1", mask_s, we_s, mv_s);
    end
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = t_mem_valid;
    end
    checks++;
    if (i_rsp_valid !== 1'b0) begin errors++; $display("FAIL lw_early_rsp: got %0b expected 0", i_rsp_valid); end
    @(negedge clk);
    checks++;
    if (i_rsp_valid !== 1'b1) begin errors++; $display("FAIL lw_rsp_latency: got %0b expected 1", i_rsp_valid); end
    drain();
  endtask

  task automatic test_byte();
    send(1'b1, 3'd0, 32'h21, 32'h80, 1'b0, 32'h0);
    checks++;
    if (mask_s !== 4'b0010 || mdata_s !== 32'h80808080) begin
      errors++;
      $display("FAIL sb_req: got mask=%b data=%08h expected 0010 80808080", mask_s, mdata_s);
    end
    send(1'b0, 3'd0, 32'h21, 32'h0, 1'b0, 32'hFFFFFF80);
    send(1'b0, 3'd4, 32'h21, 32'h0, 1'b0, 32'h00000080);
    drain();
  endtask

  task automatic test_half();
    send(1'b1, 3'd1, 32'h32, 32'h8001, 1'b0, 32'h0);
    checks++;
    if (mask_s !== 4'b1100 || mdata_s !== 32'h80018001) begin
      errors++;
      $display("FAIL sh_req: got mask=%b data=%08h expected 1100 80018001", mask_s, mdata_s);
    end
    send(1'b0, 3'd1, 32'h32, 32'h0, 1'b0, 32'hFFFF8001);
    send(1'b0, 3'd5, 32'h32, 32'h0, 1'b0, 32'h00008001);
    drain();
  endtask

  task automatic test_errors();
    logic [2:0]  f3s [3] = '{3'd2, 3'd1, 3'd3};
    logic [31:0] ads [3] = '{32'h41, 32'h43, 32'h40};
    for (int i = 0; i < 3; i++) begin
      send(1'b0, f3s[i], ads[i], 32'h0, 1'b1, 32'h0);
      checks++;
      if (mv_s !== 1'b0) begin errors++; $display("FAIL err_mem_valid[%0d]: got %0b expected 0", i, mv_s); end
    end
    drain();
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    i_rsp_ready = 1'b0;
    send(1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
    send(1'b0, 3'd2, 32'h20, 32'h0, 1'b0, 32'h00008000);
    drive_req(1'b0, 3'd2, 32'h30, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (t_req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %0b expected 0", i, t_req_ready); end
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 2) begin errors++; $display("FAIL bp_accepted: got %0d expected 2", exp_q.size()); end
    i_rsp_ready = 1'b1;
    wait_accept(1'b0, 32'h80010000);
    drain();
  endtask

  task automatic test_reset_inflight();
    send(1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
    rstf = 1'b0;
    exp_q.delete();
    #2 rstf = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (i_rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_stale_rsp[%0d]: got %0b expected 0", i, i_rsp_valid); end
    end
    send(1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
    drain();
  endtask

  initial begin
    test_reset();
    test_sw_lw();
    test_byte();
    test_half();
    test_errors();
    test_back_to_back();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
